// File: rtl/tfc_pkg.sv
// Shared encodings for the actuated intersection controller: light codes,
// phase states, served-direction tags and small state-to-lamp helpers.
package tfc_pkg;

  localparam logic [1:0] LT_RED = 2'b00;
  localparam logic [1:0] LT_YEL = 2'b01;
  localparam logic [1:0] LT_GRN = 2'b10;

  localparam logic DIR_NS = 1'b0;
  localparam logic DIR_EW = 1'b1;

  typedef enum logic [2:0] {
    NS_GRN = 3'd0,
    NS_YEL = 3'd1,
    ALLRED = 3'd2,
    EW_GRN = 3'd3,
    EW_YEL = 3'd4,
    WALK   = 3'd5
  } state_e;

  function automatic logic [1:0] ns_light(state_e s);
    case (s)
      NS_GRN:  return LT_GRN;
      NS_YEL:  return LT_YEL;
      default: return LT_RED;
    endcase
  endfunction

  function automatic logic [1:0] ew_light(state_e s);
    case (s)
      EW_GRN:  return LT_GRN;
      EW_YEL:  return LT_YEL;
      default: return LT_RED;
    endcase
  endfunction

  function automatic state_e green_of(logic dir);
    return (dir == DIR_NS) ? NS_GRN : EW_GRN;
  endfunction

endpackage

// File: rtl/tfc_phase_timer.sv
// Tick-enabled phase timer: clears when a new state is entered, otherwise
// counts ticks and saturates; e is the count this tick would produce.
module tfc_phase_timer #(
  parameter int CNT_W   = 8,
  parameter int MAX_CNT = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             clr,
  output logic [CNT_W-1:0] e
);

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_CNT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign e = cnt_q + CNT_W'(1);

  always_comb begin
    cnt_d = cnt_q;
    if (tick) cnt_d = clr ? '0 : ((e >= MAX_C) ? MAX_C : e);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/tfc_actuated_ctrl.sv
// Actuated NS/EW/pedestrian phase scheduler with sensor-driven green
// extension, yellow and all-red clearance, and a latched walk request.
module tfc_actuated_ctrl
  import tfc_pkg::*;
#(
  parameter int MIN_GREEN = 4,
  parameter int MAX_GREEN = 12,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 1,
  parameter int WALK_T    = 6,
  parameter int CNT_W     = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       ns_car,
  input  logic       ew_car,
  input  logic       ped_req,
  output logic [1:0] NS,
  output logic [1:0] EW,
  output logic       walk,
  output logic [2:0] phase
);

  localparam logic [CNT_W-1:0] MIN_G  = CNT_W'(MIN_GREEN);
  localparam logic [CNT_W-1:0] MAX_G  = CNT_W'(MAX_GREEN);
  localparam logic [CNT_W-1:0] YEL_C  = CNT_W'(YELLOW_T);
  localparam logic [CNT_W-1:0] AR_C   = CNT_W'(ALLRED_T);
  localparam logic [CNT_W-1:0] WALK_C = CNT_W'(WALK_T);

  state_e           state_q, state_d;
  logic             last_q, last_d;
  logic             ped_pend_q, ped_pend_d;
  logic [1:0]       ns_q, ns_d, ew_q, ew_d;
  logic             walk_q, walk_d;
  logic [CNT_W-1:0] e;
  logic             opp_car, last_car;

  tfc_phase_timer #(.CNT_W(CNT_W), .MAX_CNT(MAX_GREEN)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick),
    .clr   (state_d != state_q),
    .e     (e)
  );

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    opp_car  = (last_q == DIR_NS) ? ew_car : ns_car;
    last_car = (last_q == DIR_NS) ? ns_car : ew_car;
    if (tick) begin
      case (state_q)
        NS_GRN: if ((ew_car || ped_pend_q) && ((e >= MIN_G && !ns_car) || e >= MAX_G))
                  state_d = NS_YEL;
        NS_YEL: if (e == YEL_C) begin
                  state_d = ALLRED;
                  last_d  = DIR_NS;
                end
        EW_GRN: if ((ns_car || ped_pend_q) && ((e >= MIN_G && !ew_car) || e >= MAX_G))
                  state_d = EW_YEL;
        EW_YEL: if (e == YEL_C) begin
                  state_d = ALLRED;
                  last_d  = DIR_EW;
                end
        // Walk first, then alternate, unless only the last-served side is waiting.
        ALLRED: if (e == AR_C) begin
                  if (ped_pend_q)                state_d = WALK;
                  else if (!opp_car && last_car) state_d = green_of(last_q);
                  else                           state_d = green_of(!last_q);
                end
        WALK:   if (e == WALK_C) state_d = ALLRED;
        default: state_d = ALLRED;
      endcase
    end
    // A press on the walk-entry cycle survives, earning another walk later.
    ped_pend_d = ped_req || (ped_pend_q && !(state_d == WALK && state_q != WALK));
    ns_d       = ns_light(state_d);
    ew_d       = ew_light(state_d);
    walk_d     = (state_d == WALK);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ALLRED;
      last_q     <= DIR_EW;
      ped_pend_q <= 1'b0;
      ns_q       <= LT_RED;
      ew_q       <= LT_RED;
      walk_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      ped_pend_q <= ped_pend_d;
      ns_q       <= ns_d;
      ew_q       <= ew_d;
      walk_q     <= walk_d;
    end
  end

  assign NS    = ns_q;
  assign EW    = ew_q;
  assign walk  = walk_q;
  assign phase = state_q;

endmodule

// File: tb/tb_tfc_actuated_ctrl.sv
// Directed bench for tfc_actuated_ctrl: a table of per-cycle input/expected
// records plus a hand-written reset-during-yellow sequence.
module tb_tfc_actuated_ctrl;
  import tfc_pkg::*;

  localparam logic [1:0] G = 2'b10;
  localparam logic [1:0] Y = 2'b01;
  localparam logic [1:0] R = 2'b00;

  typedef struct {
    bit         rst;
    int         rep;
    bit         tk, nsc, ewc, ped;
    logic [1:0] ens, eew;
    bit         ewk;
    logic [2:0] eph;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       tick = 1'b0, ns_car = 1'b0, ew_car = 1'b0, ped_req = 1'b0;
  logic [1:0] NS, EW;
  logic       walk;
  logic [2:0] phase;

  int   nvec = 0;
  int   nerr = 0;
  bit   armed = 1'b0;
  vec_t vq[$];

  tfc_actuated_ctrl dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .ns_car(ns_car), .ew_car(ew_car),
    .ped_req(ped_req), .NS(NS), .EW(EW), .walk(walk), .phase(phase)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (armed) begin
      nvec++;
      if ((NS != R && EW != R) || NS == 2'b11 || EW == 2'b11 ||
          (walk && (NS != R || EW != R || phase != WALK))) begin
        nerr++;
        $display("FAIL invariant @%0t: NS=%b EW=%b walk=%b phase=%0d", $time, NS, EW, walk, phase);
      end
    end
  end

  task automatic add(input bit rst, input int rep, input bit tk, nsc, ewc, ped,
                     input logic [1:0] ens, eew, input bit ewk, input logic [2:0] eph);
    vec_t v;
    v.rst = rst; v.rep = rep; v.tk = tk; v.nsc = nsc; v.ewc = ewc; v.ped = ped;
    v.ens = ens; v.eew = eew; v.ewk = ewk; v.eph = eph;
    vq.push_back(v);
  endtask

  task automatic check(input string nm, input logic [1:0] ens, eew, input logic ewk,
                       input logic [2:0] eph);
    nvec++;
    if (NS !== ens || EW !== eew || walk !== ewk || phase !== eph) begin
      nerr++;
      $display("FAIL %s: got NS=%b EW=%b walk=%b phase=%0d, want NS=%b EW=%b walk=%b phase=%0d",
               nm, NS, EW, walk, phase, ens, eew, ewk, eph);
    end
  endtask

  task automatic do_reset(input string nm);
    @(negedge clk);
    rst_n = 1'b0; tick = 1'b0; ns_car = 1'b0; ew_car = 1'b0; ped_req = 1'b0;
    #1 check(nm, R, R, 1'b0, ALLRED);
    @(negedge clk);
    rst_n = 1'b1;
    armed = 1'b1;
  endtask

  task automatic step(input bit tk, nsc, ewc, ped);
    @(negedge clk);
    tick = tk; ns_car = nsc; ew_car = ewc; ped_req = ped;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

  initial begin
    // Defaults: one all-red tick, then NS green rests with no demand.
    add(1, 0, 0, 0, 0, 0, R, R, 0, ALLRED);
    add(0, 1, 1, 0, 0, 0, G, R, 0, NS_GRN);
    add(0, 50, 1, 0, 0, 0, G, R, 0, NS_GRN);
    // Demand arriving after max green has elapsed exits on the next tick.
    add(0, 1, 1, 1, 1, 0, Y, R, 0, NS_YEL);
    add(0, 2, 1, 1, 1, 0, Y, R, 0, NS_YEL);
    add(0, 1, 1, 1, 1, 0, R, R, 0, ALLRED);
    add(0, 1, 1, 1, 1, 0, R, G, 0, EW_GRN);
    // Both cars held: max-out on each side.
    add(0, 11, 1, 1, 1, 0, R, G, 0, EW_GRN);
    add(0, 1, 1, 1, 1, 0, R, Y, 0, EW_YEL);
    add(0, 2, 1, 1, 1, 0, R, Y, 0, EW_YEL);
    add(0, 1, 1, 1, 1, 0, R, R, 0, ALLRED);
    add(0, 1, 1, 1, 1, 0, G, R, 0, NS_GRN);
    add(0, 11, 1, 1, 1, 0, G, R, 0, NS_GRN);
    add(0, 1, 1, 1, 1, 0, Y, R, 0, NS_YEL);
    add(0, 2, 1, 1, 1, 0, Y, R, 0, NS_YEL);
    add(0, 1, 1, 1, 1, 0, R, R, 0, ALLRED);
    add(0, 1, 1, 1, 1, 0, R, G, 0, EW_GRN);
    // Single ped pulse in EW green with no cars.
    add(0, 1, 1, 0, 0, 1, R, G, 0, EW_GRN);
    add(0, 2, 1, 0, 0, 0, R, G, 0, EW_GRN);
    add(0, 1, 1, 0, 0, 0, R, Y, 0, EW_YEL);
    add(0, 2, 1, 0, 0, 0, R, Y, 0, EW_YEL);
    add(0, 1, 1, 0, 0, 0, R, R, 0, ALLRED);
    add(0, 1, 1, 0, 0, 0, R, R, 1, WALK);
    add(0, 5, 1, 0, 0, 0, R, R, 1, WALK);
    add(0, 1, 1, 0, 0, 0, R, R, 0, ALLRED);
    add(0, 1, 1, 0, 0, 0, G, R, 0, NS_GRN);
    add(0, 8, 1, 0, 0, 0, G, R, 0, NS_GRN);
    // Return to last-served green when only that side is waiting.
    add(0, 1, 1, 0, 1, 0, Y, R, 0, NS_YEL);
    add(0, 2, 1, 0, 1, 0, Y, R, 0, NS_YEL);
    add(0, 1, 1, 0, 1, 0, R, R, 0, ALLRED);
    add(0, 1, 1, 1, 0, 0, G, R, 0, NS_GRN);
    // Opposing car from green entry: 4 green, 3 yellow, 1 all-red.
    add(0, 3, 1, 0, 1, 0, G, R, 0, NS_GRN);
    add(0, 1, 1, 0, 1, 0, Y, R, 0, NS_YEL);
    add(0, 2, 1, 0, 1, 0, Y, R, 0, NS_YEL);
    add(0, 1, 1, 0, 1, 0, R, R, 0, ALLRED);
    add(0, 1, 1, 0, 1, 0, R, G, 0, EW_GRN);
    // Ped held on the walk-entry cycle buys a second walk.
    add(0, 1, 1, 0, 0, 1, R, G, 0, EW_GRN);
    add(0, 2, 1, 0, 0, 0, R, G, 0, EW_GRN);
    add(0, 1, 1, 0, 0, 0, R, Y, 0, EW_YEL);
    add(0, 2, 1, 0, 0, 0, R, Y, 0, EW_YEL);
    add(0, 1, 1, 0, 0, 0, R, R, 0, ALLRED);
    add(0, 1, 1, 0, 0, 1, R, R, 1, WALK);
    add(0, 5, 1, 0, 0, 0, R, R, 1, WALK);
    add(0, 1, 1, 0, 0, 0, R, R, 0, ALLRED);
    add(0, 1, 1, 0, 0, 0, R, R, 1, WALK);
    add(0, 5, 1, 0, 0, 0, R, R, 1, WALK);
    add(0, 1, 1, 0, 0, 0, R, R, 0, ALLRED);
    add(0, 1, 1, 0, 0, 0, G, R, 0, NS_GRN);
    // Tick every 4th cycle: durations stretch, nothing moves between ticks.
    add(1, 0, 0, 0, 0, 0, R, R, 0, ALLRED);
    add(0, 3, 0, 0, 0, 0, R, R, 0, ALLRED);
    add(0, 1, 1, 0, 0, 0, G, R, 0, NS_GRN);
    for (int k = 0; k < 3; k++) begin
      add(0, 3, 0, 0, 1, 0, G, R, 0, NS_GRN);
      add(0, 1, 1, 0, 1, 0, G, R, 0, NS_GRN);
    end
    add(0, 3, 0, 0, 1, 0, G, R, 0, NS_GRN);
    add(0, 1, 1, 0, 1, 0, Y, R, 0, NS_YEL);
    for (int k = 0; k < 2; k++) begin
      add(0, 3, 0, 0, 1, 0, Y, R, 0, NS_YEL);
      add(0, 1, 1, 0, 1, 0, Y, R, 0, NS_YEL);
    end
    add(0, 3, 0, 0, 1, 0, Y, R, 0, NS_YEL);
    add(0, 1, 1, 0, 1, 0, R, R, 0, ALLRED);
    add(0, 3, 0, 0, 1, 0, R, R, 0, ALLRED);
    add(0, 1, 1, 0, 1, 0, R, G, 0, EW_GRN);

    for (int i = 0; i < vq.size(); i++) begin
      if (vq[i].rst) begin
        do_reset($sformatf("row%0d_reset", i));
      end else begin
        for (int r = 0; r < vq[i].rep; r++) begin
          step(vq[i].tk, vq[i].nsc, vq[i].ewc, vq[i].ped);
          check($sformatf("row%0d.%0d", i, r), vq[i].ens, vq[i].eew, vq[i].ewk, vq[i].eph);
        end
      end
    end

    // Asynchronous reset in the middle of NS yellow, with a ped press pending.
    do_reset("seq_reset");
    step(1, 0, 0, 0);
    check("seq_ns_grn", G, R, 1'b0, NS_GRN);
    repeat (3) step(1, 0, 1, 0);
    check("seq_ns_grn_hold", G, R, 1'b0, NS_GRN);
    step(1, 0, 1, 0);
    check("seq_ns_yel", Y, R, 1'b0, NS_YEL);
    step(1, 0, 1, 1);
    check("seq_ns_yel_ped", Y, R, 1'b0, NS_YEL);
    #2 rst_n = 1'b0;
    #1 check("seq_async_reset", R, R, 1'b0, ALLRED);
    @(posedge clk);
    #1 check("seq_reset_held", R, R, 1'b0, ALLRED);
    @(negedge clk);
    rst_n = 1'b1; tick = 1'b0; ns_car = 1'b0; ew_car = 1'b0; ped_req = 1'b0;
    step(0, 0, 0, 0);
    check("seq_after_rel_allred", R, R, 1'b0, ALLRED);
    step(1, 0, 0, 0);
    check("seq_after_rel_ns_grn", G, R, 1'b0, NS_GRN);
    repeat (6) begin
      step(1, 0, 0, 0);
      check("seq_ped_lost_rest", G, R, 1'b0, NS_GRN);
    end

    armed = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/tfc_actuated_ctrl.md
Name: tfc_actuated_ctrl

Overview:
Actuated phase scheduler for a two-way intersection. It shares the crossing between the north-south approach, the east-west approach and a pedestrian crossing. It uses vehicle-presence sensors, a latched pedestrian button and tick-based min/max green, yellow, all-red and walk timers. It drives the same 2-bit NS/EW light buses as tfc and adds a walk output, so it is a drop-in actuated replacement for the fixed-time tfc.

Parameters:
MIN_GREEN, 4, minimum green duration in ticks (>=1)
MAX_GREEN, 12, maximum green duration in ticks while opposing demand exists (>=MIN_GREEN)
YELLOW_T, 3, yellow duration in ticks (>=1)
ALLRED_T, 1, all-red clearance duration in ticks (>=1)
WALK_T, 6, pedestrian walk duration in ticks (>=1)
CNT_W, 8, phase timer width; must hold MAX_GREEN

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
tick  in  1  one-cycle timebase enable; all timing is counted in ticks
ns_car  in  1  NS vehicle present (level)
ew_car  in  1  EW vehicle present (level)
ped_req  in  1  pedestrian button (pulse or level)
NS  out  2  NS light: 2'b00 RED, 2'b01 YELLOW, 2'b10 GREEN (2'b11 never driven)
EW  out  2  EW light, same encoding
walk  out  1  pedestrian walk lamp
phase  out  3  current state encoding, for debug

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low. All outputs are registered and reflect the current state.
- Reset values: state ALLRED, last_served=EW, ped_pend=0, cnt=0, NS=RED, EW=RED, walk=0, phase=ALLRED.
- States and outputs:
  - NS_GRN: NS=GREEN, EW=RED.
  - NS_YEL: NS=YELLOW, EW=RED.
  - EW_GRN: EW=GREEN, NS=RED.
  - EW_YEL: EW=YELLOW, NS=RED.
  - ALLRED: both RED, walk=0.
  - WALK: both RED, walk=1.
- Timer:
  - cnt clears to 0 on every state entry.
  - On a cycle with tick=1, let e=cnt+1. If the state's exit condition holds, transition; otherwise cnt<=e, saturating at MAX_GREEN.
  - No transition ever occurs on a cycle with tick=0.
- ped_pend: set on any cycle with ped_req=1 and cleared on entry to WALK. If ped_req is high on the entry cycle, set wins, giving one further walk cycle later.
- Demand: for NS_GRN, demand_other = ew_car | ped_pend. For EW_GRN, demand_other = ns_car | ped_pend.
- Green exit (NS_GRN; EW_GRN is symmetric with ew_car as own_car):
  - Go to yellow when demand_other && ((e>=MIN_GREEN && !own_car) || e>=MAX_GREEN).
  - With no opposing demand, green rests indefinitely.
  - Exit is evaluated on every tick. Demand arriving after MAX_GREEN has elapsed causes an exit on the next tick.
- Yellow: NS_YEL/EW_YEL -> ALLRED when e==YELLOW_T. The state that entered ALLRED sets last_served (NS_YEL sets NS, EW_YEL sets EW).
- ALLRED exit when e==ALLRED_T, evaluated in priority order:
  1. ped_pend -> WALK.
  2. Otherwise go to the green opposite last_served.
  3. If that direction has no car but last_served's direction does, return to last_served's green.
  4. If neither has a car, go to the green opposite last_served.
- WALK -> ALLRED when e==WALK_T. last_served is unchanged, so the next green is still the opposite direction.
- Safety invariant: NS and EW are never both non-RED. walk=1 only in WALK. GREEN is never entered directly from YELLOW or WALK.
- Sensors are sampled only on tick cycles. Inputs are already synchronous to clk; no synchroniser is included.
- Reset mid-phase: outputs go to RED/RED/0 immediately (asynchronous). After release, the sequence restarts from ALLRED with ped_pend lost.

Decomposition:
- tfc_pkg holds:
  - light encodings: LT_RED, LT_YEL, LT_GRN;
  - the state localparams/enum: NS_GRN, NS_YEL, ALLRED, EW_GRN, EW_YEL, WALK;
  - the DIR_NS/DIR_EW constants.
- One sub-module, tfc_phase_timer: tick-enabled saturating counter with synchronous clear-on-entry, exposing e (cnt+1).

Test Plan:
1. Reset, then tick held high, no cars, no ped (defaults) -> ALLRED for 1 tick, then NS_GRN resting indefinitely; NS=2'b10, EW=2'b00 after 50 ticks.
2. In NS_GRN with ns_car=0, ew_car=1 from tick 0 -> NS green 4 ticks, yellow 3, all-red 1, then EW=2'b10.
3. In NS_GRN with ns_car=1 and ew_car=1 held -> NS green lasts exactly 12 ticks (max-out), then yellow; EW gets green 4 ticks later.
4. One-cycle ped_req pulse during EW_GRN with no cars -> EW yellow after 4 green ticks, ALLRED 1, WALK (walk=1) for 6 ticks, ALLRED 1, then NS_GRN; ped_pend cleared on WALK entry.
5. tick pulsed every 4th cycle -> every state duration scales by 4 cycles; no state change on non-tick cycles.
6. rst_n asserted mid-NS_YEL -> NS/EW/walk read RED/RED/0 in the same cycle; after release the bench sees ALLRED then NS_GRN, and NS/EW are never both non-RED throughout (invariant checked every cycle).
